reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/rob_pkg.sv | 22 ++
 rtl/rob_retire_select.sv | 29 ++
 rtl/reorder_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg -- shared definitions for the reorder buffer.
//   Holds the parameter defaults used by reorder_buffer and the record
//   stored in every buffer entry. The entry record uses the default
//   physical-register width, so reorder_buffer is meant to be built with
//   AR_SIZE equal to AR_SIZE_DEF.
package rob_pkg;

  localparam int ROB_SIZE_DEF = 16;
  localparam int ROB_IDX_DEF  = 4;
  localparam int AR_SIZE_DEF  = 7;
  localparam int FU_ARRAY_DEF = 3;

  typedef struct packed {
    logic                   valid;
    logic                   complete;
    logic                   has_rd;
    logic [AR_SIZE_DEF-1:0] rd;
    logic [AR_SIZE_DEF-1:0] old_rd;
    logic [31:0]            value;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// rob_retire_select -- chooses which of the two oldest entries retire.
//   head_i      : index of the oldest entry
//   count_i     : number of occupied entries
//   complete_i  : per-entry "valid and complete" vector
//   slot1_*_o   : first retire slot (always the head entry)
//   slot2_*_o   : second retire slot (entry after head, only behind slot 1)
module rob_retire_select #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_IDX  = 4
) (
  input  logic [ROB_IDX-1:0] head_i,
  input  logic [ROB_IDX:0]   count_i,
  input  logic [ROB_SIZE-1:0] complete_i,
  output logic               slot1_valid_o,
  output logic [ROB_IDX-1:0] slot1_idx_o,
  output logic               slot2_valid_o,
  output logic [ROB_IDX-1:0] slot2_idx_o
);

  always_comb begin
    slot1_idx_o = head_i;
    slot2_idx_o = (head_i == ROB_IDX'(ROB_SIZE - 1)) ? '0 : head_i + 1'b1;
    // Slot 2 only follows a retiring slot 1, which keeps retirement in order.
    slot1_valid_o = (count_i != '0) && complete_i[slot1_idx_o];
    slot2_valid_o = slot1_valid_o && (count_i >= (ROB_IDX+1)'(2)) &&
                    complete_i[slot2_idx_o];
  end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer -- circular in-order retirement buffer.
//   clk, rstn              : clock, asynchronous active-low reset
//   alloc_*_in             : dispatch allocation request and entry fields
//   alloc_tag_out          : tag handed to the instruction (current tail)
//   stall                  : buffer full, dispatch must hold
//   wb_valid/tag/value_in  : FU_ARRAY write-back ports, port 0 in the LSBs
//   retire_*_out1/out2     : up to two in-order retirements per cycle
//   count_out              : occupied entries, 0..ROB_SIZE
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF,
  parameter int ROB_IDX  = ROB_IDX_DEF,
  parameter int AR_SIZE  = AR_SIZE_DEF,
  parameter int FU_ARRAY = FU_ARRAY_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    alloc_valid_in,
  input  logic                    alloc_has_rd_in,
  input  logic [AR_SIZE-1:0]      alloc_rd_in,
  input  logic [AR_SIZE-1:0]      alloc_old_rd_in,
  output logic [ROB_IDX-1:0]      alloc_tag_out,
  output logic                    stall,
  input  logic [FU_ARRAY-1:0]     wb_valid_in,
  input  logic [FU_ARRAY*ROB_IDX-1:0] wb_tag_in,
  input  logic [FU_ARRAY*32-1:0]  wb_value_in,
  output logic                    retire_valid_out1,
  output logic                    retire_valid_out2,
  output logic [AR_SIZE-1:0]      retire_rd_out1,
  output logic [AR_SIZE-1:0]      retire_rd_out2,
  output logic [AR_SIZE-1:0]      retire_old_rd_out1,
  output logic [AR_SIZE-1:0]      retire_old_rd_out2,
  output logic                    retire_has_rd_out1,
  output logic                    retire_has_rd_out2,
  output logic [31:0]             retire_value_out1,
  output logic [31:0]             retire_value_out2,
  output logic [ROB_IDX:0]        count_out
);

  rob_entry_t          entry_q [ROB_SIZE];
  rob_entry_t          entry_d [ROB_SIZE];
  logic [ROB_IDX-1:0]  head_q, head_d;
  logic [ROB_IDX-1:0]  tail_q, tail_d;
  logic [ROB_IDX:0]    count_q, count_d;

  logic                wb_hit [ROB_SIZE];
  logic [31:0]         wb_val [ROB_SIZE];
  logic [ROB_SIZE-1:0] done_vec;
  logic                alloc_fire;
  logic                slot1_valid, slot2_valid;
  logic [ROB_IDX-1:0]  slot1_idx, slot2_idx;
  rob_entry_t          ret1, ret2;

  function automatic logic [ROB_IDX-1:0] ptr_inc(input logic [ROB_IDX-1:0] p);
    return (p == ROB_IDX'(ROB_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full is judged on registered state only: a same-cycle retire does not
  // open a slot for a same-cycle allocation.
  assign stall         = (count_q == (ROB_IDX+1)'(ROB_SIZE));
  assign alloc_fire    = alloc_valid_in && !stall;
  assign alloc_tag_out = tail_q;
  assign count_out     = count_q;

  always_comb begin
    for (int e = 0; e < ROB_SIZE; e++) begin
      done_vec[e] = entry_q[e].valid && entry_q[e].complete;
    end
  end

  rob_retire_select #(
    .ROB_SIZE (ROB_SIZE),
    .ROB_IDX  (ROB_IDX)
  ) u_retire_select (
    .head_i        (head_q),
    .count_i       (count_q),
    .complete_i    (done_vec),
    .slot1_valid_o (slot1_valid),
    .slot1_idx_o   (slot1_idx),
    .slot2_valid_o (slot2_valid),
    .slot2_idx_o   (slot2_idx)
  );

  // Per-entry write-back match; scanning from port 0 with a hit flag makes
  // the lowest-numbered port win when several target the same tag.
  always_comb begin
    for (int e = 0; e < ROB_SIZE; e++) begin
      wb_hit[e] = 1'b0;
      wb_val[e] = '0;
      for (int p = 0; p < FU_ARRAY; p++) begin
        if (!wb_hit[e] && wb_valid_in[p] &&
            wb_tag_in[p*ROB_IDX +: ROB_IDX] == ROB_IDX'(e)) begin
          wb_hit[e] = 1'b1;
          wb_val[e] = wb_value_in[p*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    entry_d = entry_q;
    for (int e = 0; e < ROB_SIZE; e++) begin
      if (wb_hit[e] && entry_q[e].valid && !entry_q[e].complete) begin
        entry_d[e].complete = 1'b1;
        entry_d[e].value    = wb_val[e];
      end
    end
    // Retiring entries are complete, so no write-back above can touch them.
    if (slot1_valid) entry_d[slot1_idx] = '0;
    if (slot2_valid) entry_d[slot2_idx] = '0;
    // When not full the tail entry is free, so it never collides with retire.
    if (alloc_fire) begin
      entry_d[tail_q]          = '0;
      entry_d[tail_q].valid    = 1'b1;
      entry_d[tail_q].has_rd   = alloc_has_rd_in;
      entry_d[tail_q].rd       = alloc_rd_in;
      entry_d[tail_q].old_rd   = alloc_old_rd_in;
    end

    head_d  = slot2_valid ? ptr_inc(slot2_idx) : (slot1_valid ? slot2_idx : head_q);
    tail_d  = alloc_fire ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + (ROB_IDX+1)'(alloc_fire)
                      - (ROB_IDX+1)'(slot1_valid) - (ROB_IDX+1)'(slot2_valid);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < ROB_SIZE; e++) entry_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Invalid slots present all-zero data.
  always_comb begin
    ret1 = slot1_valid ? entry_q[slot1_idx] : '0;
    ret2 = slot2_valid ? entry_q[slot2_idx] : '0;
  end

  assign retire_valid_out1  = slot1_valid;
  assign retire_valid_out2  = slot2_valid;
  assign retire_has_rd_out1 = ret1.has_rd;
  assign retire_has_rd_out2 = ret2.has_rd;
  assign retire_rd_out1     = ret1.rd;
  assign retire_rd_out2     = ret2.rd;
  assign retire_old_rd_out1 = ret1.old_rd;
  assign retire_old_rd_out2 = ret2.old_rd;
  assign retire_value_out1  = ret1.value;
  assign retire_value_out2  = ret2.value;

endmodule
